// File: rtl/core_task_scheduler.sv
// Round-robin task dispatcher: accepts a task, issues a one-hot start strobe to one free node.
// Latency: handshake at edge k -> start during cycle k+1; task_ready drops while issuing or when no node is free.
module core_task_scheduler #(
    parameter int NODES  = 9,
    parameter int TASK_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       task_valid,
    input  logic [TASK_W-1:0]          task_id,
    output logic                       task_ready,
    input  logic [NODES-1:0]           core_avail,
    input  logic [NODES-1:0]           core_done,
    output logic [NODES-1:0]           start,
    output logic [TASK_W-1:0]          start_task,
    output logic [$clog2(NODES)-1:0]   start_node,
    output logic [NODES-1:0]           busy_mask,
    output logic [$clog2(NODES+1)-1:0] active_count
);
    localparam int IDX_W = $clog2(NODES);
    localparam int CNT_W = $clog2(NODES+1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  sel_q;
    logic [IDX_W-1:0]  sel_c;
    logic [TASK_W-1:0] task_q;
    logic [NODES-1:0]  free;
    logic [NODES-1:0]  set_vec;
    logic [NODES-1:0]  busy_next;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W:0]    scan_idx;
    logic              sel_found;
    logic              issue_en;
    logic              accept;

    assign free       = core_avail & ~busy_mask;
    assign task_ready = rst_n && (state == S_IDLE) && (|free);
    assign accept     = task_valid && task_ready;
    // A reset landing on the issue cycle swallows the strobe.
    assign issue_en   = rst_n && (state == S_ISSUE);

    always_comb begin
        sel_found = 1'b0;
        sel_c     = '0;
        scan_idx  = '0;
        for (int i = 0; i < NODES; i++) begin
            scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (scan_idx >= (IDX_W+1)'(NODES)) begin
                scan_idx = scan_idx - (IDX_W+1)'(NODES);
            end
            if (!sel_found && free[scan_idx[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_c     = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        set_vec = '0;
        if (issue_en) begin
            set_vec[sel_q] = 1'b1;
        end
    end

    // Set is ORed in after the clear so a same-cycle done on the issued node loses.
    assign busy_next = (busy_mask & ~core_done) | set_vec;

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NODES; i++) begin
            cnt_next = cnt_next + CNT_W'(busy_next[i]);
        end
    end

    assign start      = set_vec;
    assign start_task = issue_en ? task_q : '0;
    assign start_node = issue_en ? sel_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            sel_q        <= '0;
            task_q       <= '0;
            busy_mask    <= '0;
            active_count <= '0;
        end else begin
            busy_mask    <= busy_next;
            active_count <= cnt_next;
            if (state == S_IDLE) begin
                if (accept) begin
                    task_q <= task_id;
                    sel_q  <= sel_c;
                    state  <= S_ISSUE;
                end
            end else begin
                rr_ptr <= (sel_q == IDX_W'(NODES-1)) ? '0 : sel_q + IDX_W'(1);
                state  <= S_IDLE;
            end
        end
    end
endmodule

// File: doc/core_task_scheduler.md
# core_task_scheduler

Central task dispatcher for the 3x3 mesh. It accepts tasks over a valid/ready interface and tracks which `cpu_with_ram` nodes are both available and idle. Each accepted task goes to exactly one free node, chosen round-robin, with a one-cycle start strobe. The per-node availability vector it consumes is the same signal the mesh top level feeds to `noc`. Per-node done pulses release nodes for reuse.

## Interface
Parameters:
- `NODES`, 9 — number of mesh nodes (`X`*`Y`); node id = row*`X`+column.
- `TASK_W`, 8 — width of task identifier.

Ports:
- `clk`  in  1  — system clock; single clock domain.
- `rst_n`  in  1  — reset; synchronous, active-low.
- `task_valid`  in  1  — task offered.
- `task_id`  in  `TASK_W`  — task identifier, sampled on handshake.
- `task_ready`  out  1  — scheduler can accept a task this cycle.
- `core_avail`  in  `NODES`  — bit n = node n is populated/available (`core_availability_signals_out`, flattened).
- `core_done`  in  `NODES`  — bit n single-cycle pulse = node n finished its task.
- `start`  out  `NODES`  — one-hot, single-cycle start strobe to selected node.
- `start_task`  out  `TASK_W`  — task id accompanying `start`.
- `start_node`  out  `$clog2(NODES)`  — binary index of node in `start`.
- `busy_mask`  out  `NODES`  — bit n = node n holds a task.
- `active_count`  out  `$clog2(NODES+1)`  — popcount of `busy_mask`.

## Operation
- Free vector: `free[n] = core_avail[n] & ~busy_mask[n]`.
- The FSM has 2 states: IDLE and ISSUE.
- In IDLE:
  - `task_ready = |free`.
  - On `task_valid & task_ready`, the scheduler latches `task_id`.
  - It selects node `sel` = first set bit of `free` scanning `rr_ptr`, `rr_ptr+1`, …, `NODES-1`, 0, …, `rr_ptr-1`.
  - It latches `sel` and moves to ISSUE.
- In ISSUE:
  - `task_ready = 0`.
  - `start[sel] = 1`; `start_task` and `start_node` carry the latched values.
  - `busy_mask[sel]` is set at the end of the cycle.
  - `rr_ptr <= (sel == NODES-1) ? 0 : sel+1`.
  - Next state is IDLE.
- The latched `sel` is issued even if `core_avail[sel]` drops during ISSUE; there is no re-selection.
- `core_done[n]` clears `busy_mask[n]` at the clock edge.
  - Done for a non-busy node is ignored.
  - Set and clear on the same node in the same cycle: set wins. This cannot occur legally, but the behaviour is defined.
- Multiple `core_done` bits in one cycle are all honoured.
- `active_count` is registered, consistent with `busy_mask` in the same cycle.
- `start_task`/`start_node` are 0 when `start` is 0.
- `core_avail` low on a busy node does not clear busy; only `core_done` does.

## Timing
- Reset (`rst_n` low at a clock edge):
  - Outputs: `start=0`, `start_task=0`, `start_node=0`, `busy_mask=0`, `active_count=0`, `task_ready=0`.
  - Internal: state=IDLE, `rr_ptr=0`.
- `task_ready` is combinational from state, `busy_mask` and `core_avail`. It is low in the cycle `rst_n` is low.
- Handshake at edge k produces `start` high during cycle k+1. `busy_mask`/`active_count` update at edge k+2.
- Peak throughput is 1 task per 2 cycles.
- A `core_done` pulse at edge k makes the node selectable for a handshake at edge k+1 at the earliest.
- Reset asserted during ISSUE:
  - The start strobe is suppressed if reset is sampled before it.
  - If the strobe was already issued, it is lost.
  - All busy state is cleared; no task is retained.
- `task_id` and `task_valid` are don't-care when `task_ready` is low. The upstream holds `task_valid` until the handshake.

## Test plan
- Reset, `core_avail=9'h1FF`, offer ids 0x10..0x18 back-to-back:
  - `start` hits nodes 0..8 in order, each one cycle after its handshake.
  - `active_count=9`, `busy_mask=9'h1FF`, `task_ready=0` afterwards.
- From the full state, pulse `core_done[4]`, then offer 0x20:
  - `task_ready` rises the cycle after the pulse.
  - `start_node=4`, `start_task=0x20`.
  - `rr_ptr=5`.
- `core_avail=9'b000101010`, fresh reset, offer 3 tasks:
  - Nodes 1, 3, 5 in order.
  - The fourth task stalls (`task_ready=0`) until a done arrives.
- Wrap-around: set `rr_ptr=7` by dispatching 7 tasks, then pulse done on nodes 0..6.
  - Dispatch order is 7, 8, 0, 1, with no stall between.
- Drop `core_avail[sel]` in the ISSUE cycle:
  - `start` still fires on `sel`; busy is set.
  - `core_done` on an idle node leaves `busy_mask` unchanged.
- Assert `rst_n=0` during ISSUE:
  - No `start` pulse; all outputs 0.
  - After release, the first task goes to node 0.
